stage_4_mem: RTL and testbench
==============================

// Module: stage_4_mem
// PURPOSE
//  Stage 4 (MEM) of the 5-stage in-order core. Sits between stage_3_EX and stage 5 (WB).
//  Latches the EX payload and ALU result, and captures the synchronous data-SRAM read
//  issued in EX. Selects the write-back value (load data or ALU result), forwards it to
//  WB and publishes bypass info to ID. Uses the valid/allow handshake with back-pressure.
// PARAMETERS
//  DATA_W      32  datapath / SRAM data width
//  REG_ADDR_W  5   register-file address width
// PORTS
//  clk               in   1         clock
//  reset             in   1         synchronous, active-high reset
//  valid_3           in   1         EX holds a valid instruction
//  allow_4           out  1         MEM can accept a new instruction this cycle
//  valid_4           out  1         MEM holds a valid instruction
//  allow_5           in   1         WB can accept this cycle
//  stage_3_to_4      in   39        {rf_we, dest[4:0], res_from_mem, pc[31:0]}
//  alu_result        in   32        EX ALU result, same cycle as stage_3_to_4
//  data_sram_rdata   in   32        SRAM read data; valid the first cycle an instr is in MEM
//  stage_4_to_5      out  70        {rf_we, dest[4:0], final_result[31:0], pc[31:0]}
//  fwd_we_4          out  1         bypass: MEM will write dest (valid_4 & rf_we & dest!=0)
//  fwd_dest_4        out  5         bypass: destination register
//  fwd_data_4        out  32        bypass: final_result
// BEHAVIOUR
//  - Reset: valid_4=0, payload regs=0, alu_r=0, hold_valid=0, rdata_hold=0, first_4=0.
//    allow_4=1 and fwd_we_4=0 during and after reset.
//  - ready_go_4 = 1 (single-cycle stage). allow_4 = !valid_4 | (ready_go_4 & allow_5).
//  - Each cycle with allow_4=1: valid_4 <= valid_3.
//    If valid_3 is also 1: payload <= stage_3_to_4, alu_r <= alu_result, first_4 <= 1.
//    With allow_4=0: all regs hold and first_4 <= 0.
//  - Load data hold (skid buffer):
//    - first_4 & valid_4 & !allow_5: rdata_hold <= data_sram_rdata, hold_valid <= 1.
//    - hold_valid clears when the instruction leaves (valid_4 & allow_5), or on reset.
//    - Leave and new entry in the same cycle: clear wins; the new instr reads live rdata.
//  - mem_data = hold_valid ? rdata_hold : data_sram_rdata.
//  - final_result = res_from_mem ? mem_data : alu_r. Full 32-bit word; no sub-word extension.
//  - stage_4_to_5 rf_we field = rf_we & valid_4. Other fields pass through unmasked.
//  - Bypass outputs are combinational from the regs. Gated by valid_4 only, so a stalled
//    instruction is still forwarded.
//  - Back-to-back: one instruction per cycle when allow_5=1; zero bubbles.
//  - Reset mid-stall drops the held instruction and the held data. No output reflects it
//    in the cycle after reset.
// STRUCTURE
//  - Shared package/header: bus widths (ST34_W=39, ST45_W=70) and field offsets for
//    stage_3_to_4 / stage_4_to_5, shared with stage_3_EX and the WB stage.
//  - One sub-module, mem_rdata_hold: the 32-bit skid register plus hold_valid control
//    (inputs first, valid, allow_out, rdata_in; output rdata_out).
//  - Result mux and bypass logic stay in the top level.
// TESTING
//  1. Reset 3 cycles, valid_3=0 -> valid_4=0, allow_4=1, fwd_we_4=0, stage_4_to_5 rf_we=0.
//  2. ALU op: rf_we=1, dest=5, res_from_mem=0, alu_result=0x1234, pc=0x1C000000,
//     allow_5=1 -> next cycle valid_4=1, final_result=0x1234, fwd_dest_4=5, fwd_we_4=1.
//  3. Load: res_from_mem=1, rdata=0xDEADBEEF in first MEM cycle, allow_5=0 for 3 cycles,
//     rdata driven 0x0 afterwards -> final_result stays 0xDEADBEEF; allow_4=0 while stalled.
//  4. Stream of 4 instrs, allow_5=1 -> 4 consecutive valid_4 cycles, pcs in order, no gaps.
//  5. dest=0, rf_we=1 -> fwd_we_4=0; stage_4_to_5 rf_we=1 (WB ignores r0).
//  6. Reset asserted during a stalled load -> next cycle valid_4=0, hold_valid=0;
//     the first load after reset uses live rdata.

Source files
------------

// File: rtl/stage_4_mem_pkg.sv
// Shared definitions for the EX->MEM and MEM->WB pipeline buses.
// stage_3_EX, stage_4_mem and the WB stage all pack and unpack these buses
// with the offsets below, so a layout change only has to be made here.
//   stage_3_to_4 : {rf_we, dest, res_from_mem, pc}
//   stage_4_to_5 : {rf_we, dest, final_result, pc}
package stage_4_mem_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam int ST34_W = 1 + REG_ADDR_W + 1 + DATA_W;       // 39
    localparam int ST45_W = 1 + REG_ADDR_W + DATA_W + DATA_W;  // 70

    // stage_3_to_4 field offsets (LSB of each field)
    localparam int ST34_PC_LSB    = 0;
    localparam int ST34_RFM_BIT   = DATA_W;                    // 32
    localparam int ST34_DEST_LSB  = DATA_W + 1;                // 33
    localparam int ST34_RFWE_BIT  = DATA_W + 1 + REG_ADDR_W;   // 38

    // stage_4_to_5 field offsets (LSB of each field)
    localparam int ST45_PC_LSB    = 0;
    localparam int ST45_RES_LSB   = DATA_W;                    // 32
    localparam int ST45_DEST_LSB  = 2 * DATA_W;                // 64
    localparam int ST45_RFWE_BIT  = 2 * DATA_W + REG_ADDR_W;   // 69

endpackage

// File: rtl/stage_4_mem_rdata_hold.sv
// mem_rdata_hold: skid register for synchronous data-SRAM read data.
// The SRAM only presents the load word during the first cycle an instruction
// sits in MEM. If WB stalls that cycle, the word is captured here and served
// until the instruction leaves.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   first        first cycle of the current instruction in MEM
//   valid        MEM holds a valid instruction
//   allow_out    downstream (WB) accepts this cycle
//   rdata_in     live SRAM read data
//   rdata_out    held word when a capture is active, else live data
module mem_rdata_hold
    import stage_4_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              first,
    input  logic              valid,
    input  logic              allow_out,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [DATA_W-1:0] rdata_out
);

    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;

    always_comb begin
        hold_valid_d = hold_valid_q;
        rdata_hold_d = rdata_hold_q;
        // Leaving takes priority: a new instruction entering behind it must
        // see live SRAM data, not the previous instruction's word.
        if (valid && allow_out) begin
            hold_valid_d = 1'b0;
        end else if (first && valid && !allow_out) begin
            hold_valid_d = 1'b1;
            rdata_hold_d = rdata_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign rdata_out = hold_valid_q ? rdata_hold_q : rdata_in;

endmodule

// File: rtl/stage_4_mem.sv
// stage_4_mem: MEM stage of the 5-stage in-order core.
// Latches the EX payload and ALU result, picks load data or ALU result as the
// write-back value, forwards it to WB and publishes bypass info to ID.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   valid_3           EX holds a valid instruction
//   allow_4           MEM can accept this cycle
//   valid_4           MEM holds a valid instruction
//   allow_5           WB can accept this cycle
//   stage_3_to_4      {rf_we, dest, res_from_mem, pc}
//   alu_result        EX ALU result
//   data_sram_rdata   SRAM read data (valid first MEM cycle of a load)
//   stage_4_to_5      {rf_we, dest, final_result, pc}
//   fwd_we_4/dest/data bypass to ID
module stage_4_mem
    import stage_4_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_3,
    output logic                  allow_4,
    output logic                  valid_4,
    input  logic                  allow_5,
    input  logic [ST34_W-1:0]     stage_3_to_4,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     data_sram_rdata,
    output logic [ST45_W-1:0]     stage_4_to_5,
    output logic                  fwd_we_4,
    output logic [REG_ADDR_W-1:0] fwd_dest_4,
    output logic [DATA_W-1:0]     fwd_data_4
);

    logic                  valid_4_q, valid_4_d;
    logic                  first_4_q, first_4_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic                  res_from_mem_q, res_from_mem_d;
    logic [DATA_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]     alu_r_q, alu_r_d;

    logic                  ready_go_4;
    logic [DATA_W-1:0]     mem_data;
    logic [DATA_W-1:0]     final_result;

    assign ready_go_4 = 1'b1;
    assign allow_4    = !valid_4_q || (ready_go_4 && allow_5);

    always_comb begin
        valid_4_d      = valid_4_q;
        rf_we_d        = rf_we_q;
        dest_d         = dest_q;
        res_from_mem_d = res_from_mem_q;
        pc_d           = pc_q;
        alu_r_d        = alu_r_q;
        // first_4 is only high in the cycle right after an accepted entry.
        first_4_d      = 1'b0;
        if (allow_4) begin
            valid_4_d = valid_3;
            if (valid_3) begin
                rf_we_d        = stage_3_to_4[ST34_RFWE_BIT];
                dest_d         = stage_3_to_4[ST34_DEST_LSB +: REG_ADDR_W];
                res_from_mem_d = stage_3_to_4[ST34_RFM_BIT];
                pc_d           = stage_3_to_4[ST34_PC_LSB +: DATA_W];
                alu_r_d        = alu_result;
                first_4_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_4_q      <= 1'b0;
            first_4_q      <= 1'b0;
            rf_we_q        <= 1'b0;
            dest_q         <= '0;
            res_from_mem_q <= 1'b0;
            pc_q           <= '0;
            alu_r_q        <= '0;
        end else begin
            valid_4_q      <= valid_4_d;
            first_4_q      <= first_4_d;
            rf_we_q        <= rf_we_d;
            dest_q         <= dest_d;
            res_from_mem_q <= res_from_mem_d;
            pc_q           <= pc_d;
            alu_r_q        <= alu_r_d;
        end
    end

    mem_rdata_hold u_rdata_hold (
        .clk       (clk),
        .reset     (reset),
        .first     (first_4_q),
        .valid     (valid_4_q),
        .allow_out (allow_5),
        .rdata_in  (data_sram_rdata),
        .rdata_out (mem_data)
    );

    // Full-word loads only; no sub-word extension happens in this stage.
    assign final_result = res_from_mem_q ? mem_data : alu_r_q;

    assign valid_4      = valid_4_q;
    assign stage_4_to_5 = {rf_we_q & valid_4_q, dest_q, final_result, pc_q};

    // Gated by valid_4 only: a stalled instruction is still forwarded.
    // r0 writes are never forwarded.
    assign fwd_we_4   = valid_4_q && rf_we_q && (dest_q != '0);
    assign fwd_dest_4 = dest_q;
    assign fwd_data_4 = final_result;

endmodule

// File: tb/tb_stage_4_mem.sv
module tb_stage_4_mem;
    import stage_4_mem_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  valid_3;
    logic                  allow_4;
    logic                  valid_4;
    logic                  allow_5;
    logic [ST34_W-1:0]     stage_3_to_4;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     data_sram_rdata;
    logic [ST45_W-1:0]     stage_4_to_5;
    logic                  fwd_we_4;
    logic [REG_ADDR_W-1:0] fwd_dest_4;
    logic [DATA_W-1:0]     fwd_data_4;

    always #5 clk = ~clk;

    stage_4_mem dut (
        .clk             (clk),
        .reset           (reset),
        .valid_3         (valid_3),
        .allow_4         (allow_4),
        .valid_4         (valid_4),
        .allow_5         (allow_5),
        .stage_3_to_4    (stage_3_to_4),
        .alu_result      (alu_result),
        .data_sram_rdata (data_sram_rdata),
        .stage_4_to_5    (stage_4_to_5),
        .fwd_we_4        (fwd_we_4),
        .fwd_dest_4      (fwd_dest_4),
        .fwd_data_4      (fwd_data_4)
    );

    // expected record: {stage_4_to_5, fwd_we, fwd_dest, fwd_data}
    typedef logic [ST45_W+1+REG_ADDR_W+DATA_W-1:0] exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk_exp(input logic rf_we, input logic [4:0] dest,
                                    input logic [31:0] result, input logic [31:0] pc);
        logic fw;
        fw = rf_we && (dest != 5'd0);
        return {rf_we, dest, result, pc, fw, dest, result};
    endfunction

    // Monitor: every transfer into WB pops one expected record.
    always @(negedge clk) begin
        if (!reset && valid_4 && allow_5) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_xfer: unexpected transfer pc=0x%0h", stage_4_to_5[31:0]);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_xfer", {stage_4_to_5, fwd_we_4, fwd_dest_4, fwd_data_4}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rf_we, input logic [4:0] dest,
                         input logic rfm, input logic [31:0] pc, input logic [31:0] alu);
        valid_3      = v;
        stage_3_to_4 = {rf_we, dest, rfm, pc};
        alu_result   = alu;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; allow_5 = 1'b1; data_sram_rdata = '0;
        idle();

        // 1. reset
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("rst_valid_4", valid_4, 1'b0);
            chk("rst_allow_4", allow_4, 1'b1);
            chk("rst_fwd_we", fwd_we_4, 1'b0);
            chk("rst_wb_rfwe", stage_4_to_5[ST45_RFWE_BIT], 1'b0);
        end
        step();
        reset = 1'b0;

        // 2. ALU op
        drive(1'b1, 1'b1, 5'd5, 1'b0, 32'h1C00_0000, 32'h0000_1234);
        exp_q.push_back(mk_exp(1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000));
        step();
        idle();
        @(negedge clk);
        chk("alu_valid_4", valid_4, 1'b1);
        chk("alu_fwd_dest", fwd_dest_4, 5'd5);
        chk("alu_fwd_we", fwd_we_4, 1'b1);

        // 3. load stalled 3 cycles; SRAM data goes away after first cycle
        step();
        drive(1'b1, 1'b1, 5'd7, 1'b1, 32'h1C00_0004, 32'hAAAA_5555);
        exp_q.push_back(mk_exp(1'b1, 5'd7, 32'hDEAD_BEEF, 32'h1C00_0004));
        step();
        idle();
        allow_5 = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_allow_4", allow_4, 1'b0);
            chk("stall_result", stage_4_to_5[ST45_RES_LSB +: DATA_W], 32'hDEAD_BEEF);
            chk("stall_fwd_we", fwd_we_4, 1'b1);
            step();
            data_sram_rdata = 32'h0;
        end
        // release; a new load enters the same cycle and must read live data
        allow_5 = 1'b1;
        drive(1'b1, 1'b1, 5'd8, 1'b1, 32'h1C00_0008, 32'h0);
        exp_q.push_back(mk_exp(1'b1, 5'd8, 32'h0BAD_F00D, 32'h1C00_0008));
        step();
        idle();
        data_sram_rdata = 32'h0BAD_F00D;
        step();
        data_sram_rdata = 32'h0;

        // 4./5. back-to-back stream: ALU, rf_we=0, load, dest=r0
        drive(1'b1, 1'b1, 5'd10, 1'b0, 32'h0000_0100, 32'h0000_0011);
        exp_q.push_back(mk_exp(1'b1, 5'd10, 32'h0000_0011, 32'h0000_0100));
        step();
        drive(1'b1, 1'b0, 5'd11, 1'b0, 32'h0000_0104, 32'h0000_0022);
        exp_q.push_back(mk_exp(1'b0, 5'd11, 32'h0000_0022, 32'h0000_0104));
        @(negedge clk);
        chk("stream_valid_1", valid_4, 1'b1);
        step();
        drive(1'b1, 1'b1, 5'd12, 1'b1, 32'h0000_0108, 32'h0000_0033);
        exp_q.push_back(mk_exp(1'b1, 5'd12, 32'h55AA_55AA, 32'h0000_0108));
        @(negedge clk);
        chk("stream_valid_2", valid_4, 1'b1);
        step();
        drive(1'b1, 1'b1, 5'd0, 1'b0, 32'h0000_010C, 32'h0000_0044);
        exp_q.push_back(mk_exp(1'b1, 5'd0, 32'h0000_0044, 32'h0000_010C));
        data_sram_rdata = 32'h55AA_55AA;
        @(negedge clk);
        chk("stream_valid_3", valid_4, 1'b1);
        step();
        idle();
        data_sram_rdata = 32'h0;
        @(negedge clk);
        chk("stream_valid_4", valid_4, 1'b1);
        chk("r0_fwd_we", fwd_we_4, 1'b0);
        chk("r0_wb_rfwe", stage_4_to_5[ST45_RFWE_BIT], 1'b1);
        step();
        @(negedge clk);
        chk("stream_drained", valid_4, 1'b0);

        // 6. reset during a stalled load; that load is dropped
        step();
        drive(1'b1, 1'b1, 5'd3, 1'b1, 32'h0000_0200, 32'h0);
        step();
        idle();
        allow_5 = 1'b0;
        data_sram_rdata = 32'h1111_1111;
        step();
        data_sram_rdata = 32'h0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        allow_5 = 1'b0;
        drive(1'b1, 1'b1, 5'd9, 1'b1, 32'h0000_0204, 32'h0);
        exp_q.push_back(mk_exp(1'b1, 5'd9, 32'h2222_2222, 32'h0000_0204));
        @(negedge clk);
        chk("postrst_valid_4", valid_4, 1'b0);
        chk("postrst_allow_4", allow_4, 1'b1);
        chk("postrst_fwd_we", fwd_we_4, 1'b0);
        step();
        idle();
        data_sram_rdata = 32'h2222_2222;
        @(negedge clk);
        chk("postrst_live", stage_4_to_5[ST45_RES_LSB +: DATA_W], 32'h2222_2222);
        step();
        data_sram_rdata = 32'h0;
        allow_5 = 1'b1;
        step();
        step();

        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
